// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared widths, fetch state and queue entry types for the ARM front end
//
// Contents:
//   INST_W, ADDR_W  instruction and address widths
//   fetch_state_t   FETCH (issuing) / DRAIN (discarding stale responses)
//   fetch_entry_t   {instruction, pc} pair held in the instruction queue
//   branch_target   redirect_pc + (word offset << 2), modulo 2^ADDR_W
package arm_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 64;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] instruction;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  // The offset arrives as a sign-extended word count; shifting by two turns it
  // into a byte offset, and the carry out of bit 63 is simply dropped.
  function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] pc,
                                                      input logic [ADDR_W-1:0] offset);
    return pc + (offset << 2);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small synchronous FIFO with flush, used for the instruction queue and PC tags
//
// Parameters: WIDTH (entry width), DEPTH (entries)
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   push, din     write an entry (accepted when not full, or when popping in the same cycle)
//   pop, dout     dout is the head entry; pop advances it (ignored when empty)
//   flush         discard all entries; overrides push and pop
//   count         current number of entries
//   full, empty   occupancy flags
module fetch_buffer #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Storage is cleared on reset so the head output reads zero afterwards.
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  // The owner guarantees by credit that a push never meets a full buffer and
  // that pops only happen with data present.
  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      assert (!(push && full && !pop));
      assert (!(pop && empty));
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, instruction memory requests, in-order instruction queue
//
// Optional feature: define FETCH_PERF_EN to build the perf_fetched / perf_redirects counters;
// otherwise both outputs are tied to zero.
//
// Parameters: RESET_PC (PC after reset), BUF_DEPTH (queue entries and max outstanding requests)
// Ports:
//   clock, reset                      rising-edge clock, synchronous active-high reset
//   imem_req_valid/ready/addr         word read request; addr is always the current pc
//   imem_resp_valid/data              in-order read responses, at least one cycle after request
//   inst_valid/ready, instruction,    queue head presented to decode with its pc
//   inst_pc
//   redirect_valid/pc/offset          taken-branch pulse: target = pc + (offset << 2)
//   perf_fetched, perf_redirects      delivery and redirect counters
module instruction_fetch
  import arm_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] instruction,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [ADDR_W-1:0] redirect_offset,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_redirects
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [CNT_W-1:0]  outstanding, outstanding_next;
  logic [CNT_W-1:0]  drop, drop_next;
  logic [CNT_W-1:0]  occ_next;
  logic              req_valid_q, req_valid_next;

  logic              req_fire;
  logic              resp_keep;
  logic              resp_drop;
  logic              deliver;

  fetch_entry_t      q_din, q_dout;
  logic [CNT_W-1:0]  q_count;
  logic              q_full, q_empty;
  logic [ADDR_W-1:0] tag_pc;
  logic [CNT_W-1:0]  tag_count;
  logic              tag_full, tag_empty;

  assign req_fire  = req_valid_q && imem_req_ready;
  assign resp_drop = imem_resp_valid && (drop != '0);
  assign resp_keep = imem_resp_valid && (drop == '0);
  assign deliver   = inst_valid && inst_ready;

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc;
  assign inst_valid     = !q_empty;
  assign instruction    = q_dout.instruction;
  assign inst_pc        = q_dout.pc;

  // Responses pair up with the oldest issued PC; the tag FIFO holds only
  // requests that were issued since the last redirect.
  assign q_din = '{instruction: imem_resp_data, pc: tag_pc};

  fetch_buffer #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_inst_queue (
    .clock (clock),
    .reset (reset),
    .push  (resp_keep),
    .pop   (deliver),
    .flush (redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  fetch_buffer #(.WIDTH(ADDR_W), .DEPTH(BUF_DEPTH)) u_tag_fifo (
    .clock (clock),
    .reset (reset),
    .push  (req_fire),
    .pop   (resp_keep),
    .flush (redirect_valid),
    .din   (pc),
    .dout  (tag_pc),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    drop_next        = drop;
    outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
    occ_next         = q_count + CNT_W'(resp_keep) - CNT_W'(deliver);

    if (req_fire) begin
      pc_next = pc + 64'd4;
    end
    if (resp_drop) begin
      drop_next = drop - 1'b1;
    end

    if (redirect_valid) begin
      // Everything still in flight after this edge, including a request that
      // fires right now, belongs to the abandoned path.
      pc_next    = branch_target(redirect_pc, redirect_offset);
      drop_next  = outstanding_next;
      occ_next   = '0;
      state_next = (outstanding_next != '0) ? DRAIN : FETCH;
    end else begin
      case (state)
        FETCH:   state_next = FETCH;
        DRAIN:   if (drop_next == '0) state_next = FETCH;
        default: state_next = FETCH;
      endcase
    end

    // Valid is registered from the post-edge counts so that the memory side
    // never sees a combinational path from any input.
    req_valid_next = (state_next == FETCH) &&
                     (({1'b0, outstanding_next} + {1'b0, occ_next}) < (CNT_W + 1)'(BUF_DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      outstanding <= outstanding_next;
      drop        <= drop_next;
      req_valid_q <= req_valid_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(imem_resp_valid && outstanding == '0));
      assert (!(req_fire && tag_full));
      assert (!(resp_keep && tag_empty));
      assert (!(q_full && outstanding != '0));
      if (state == FETCH) begin
        assert (tag_count == outstanding);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q;
  logic [31:0] redirects_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetched_q   <= '0;
      redirects_q <= '0;
    end else begin
      if (deliver) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (redirect_valid) begin
        redirects_q <= redirects_q + 32'd1;
      end
    end
  end

  assign perf_fetched   = fetched_q;
  assign perf_redirects = redirects_q;
`else
  assign perf_fetched   = '0;
  assign perf_redirects = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized scoreboard bench for instruction_fetch
module tb_instruction_fetch;

  localparam logic [63:0] RPC   = 64'h100;
  localparam int          DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] redirect_offset;
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;

  always #5 clock = ~clock;

  instruction_fetch #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .instruction     (instruction),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .redirect_offset (redirect_offset),
    .perf_fetched    (perf_fetched),
    .perf_redirects  (perf_redirects)
  );

  typedef struct { logic [63:0] pc; logic [31:0] data; } exp_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  exp_t expq[$];
  rsp_t rq[$];

  int n_vec = 0, n_err = 0;
  int cyc = 0, last_due = 0, tb_out = 0;
  int n_fire = 0, n_deliv = 0, n_redir = 0;
  int rdy_pct, irdy_pct, lat_min, lat_max, redir_pct;
  int neg_idx = 0, first_fire_neg = -1, first_valid_neg = -1;
  logic [63:0] mpc;
  logic [63:0] fire_addr;
  logic        fire_seen;
  logic        redir_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every delivery handshake is matched against the oldest expected fetch.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && inst_valid && inst_ready) begin
      n_deliv++;
      if (expq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL deliver_unexpected: got pc %h, expected no delivery", inst_pc);
      end else begin
        e = expq.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("instruction", 64'(instruction), 64'(e.data));
      end
    end
  end

  // Reference model: the next accepted request must go to the model PC; each
  // accepted request on the current path becomes one expected delivery.
  task automatic observe();
    int          lat, due;
    logic [31:0] d;
    neg_idx++;
    fire_seen = 1'b0;
    if (imem_req_valid && imem_req_ready) begin
      check("credit", 64'(tb_out < DEPTH), 64'd1);
      check("req_addr", imem_req_addr, mpc);
      d   = $urandom;
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + 1 + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rq.push_back('{due, d});
      if (!redirect_valid) expq.push_back('{mpc, d});
      mpc       = mpc + 64'd4;
      tb_out++;
      n_fire++;
      fire_seen = 1'b1;
      fire_addr = imem_req_addr;
      if (first_fire_neg < 0) first_fire_neg = neg_idx;
    end
    if (imem_resp_valid) tb_out--;
    if (inst_valid && first_valid_neg < 0) first_valid_neg = neg_idx;
    redir_seen = redirect_valid;
    if (redirect_valid) begin
      mpc = redirect_pc + redirect_offset * 64'd4;
      n_redir++;
    end
  endtask

  task automatic drive();
    rsp_t r;
    int   o;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (rq.size() > 0 && rq[0].due <= cyc + 1) begin
      r = rq.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = r.data;
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    inst_ready     = ($urandom_range(99) < irdy_pct);
    redirect_valid = ($urandom_range(99) < redir_pct);
    redirect_pc    = {$urandom, $urandom} & ~64'h3;
    o = $urandom_range(64) - 32;
    redirect_offset = ($urandom_range(3) == 0) ? {$urandom, $urandom} : 64'(o);
  endtask

  task automatic step();
    @(negedge clock);
    observe();
    @(posedge clock);
    cyc++;
    if (redir_seen) expq.delete();
    #1;
    if (redir_seen) begin
      check("flush_after_redirect", 64'(inst_valid), 64'd0);
      check("req_valid_after_redirect", 64'(imem_req_valid), 64'(tb_out == 0));
    end
    drive();
  endtask

  initial begin
    logic got;
    reset = 1'b1;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0; inst_ready = 0;
    redirect_valid = 0; redirect_pc = 0; redirect_offset = 0;
    mpc = RPC;
    rdy_pct = 100; irdy_pct = 0; lat_min = 1; lat_max = 1; redir_pct = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_instruction", 64'(instruction), 64'd0);
    check("rst_inst_pc", inst_pc, 64'd0);
    check("rst_req_addr", imem_req_addr, RPC);
    check("rst_perf_fetched", 64'(perf_fetched), 64'd0);
    check("rst_perf_redirects", 64'(perf_redirects), 64'd0);
    drive();

    // Decode stalled: only BUF_DEPTH requests go out, queue holds the first two.
    for (int i = 0; i < 10; i++) step();
    check("stall_fires", 64'(n_fire), 64'(DEPTH));
    check("stall_req_valid", 64'(imem_req_valid), 64'd0);
    check("stall_inst_valid", 64'(inst_valid), 64'd1);
    check("stall_head_pc", inst_pc, RPC);
    check("fire_to_valid", 64'(first_valid_neg - first_fire_neg), 64'd2);

    // Release decode, then move to slow memory so two requests are in flight.
    irdy_pct = 100;
    for (int i = 0; i < 8; i++) step();
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 12; i++) step();
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h200;
    redirect_offset = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (fire_seen) got = 1'b1;
    end
    check("redirect_fire_seen", 64'(got), 64'd1);
    check("redirect_target_addr", fire_addr, 64'h1F8);

    // Redirect landing on a cycle with a response and a pop.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) step();
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h4000;
    redirect_offset = 64'd3;
    step();
    for (int i = 0; i < 8; i++) step();

    // Random traffic.
    rdy_pct = 70; irdy_pct = 70; lat_min = 1; lat_max = 4; redir_pct = 3;
    for (int i = 0; i < 10000; i++) step();

    // Stop issuing and let everything in flight retire.
    rdy_pct = 0; irdy_pct = 100; redir_pct = 0;
    step();
    for (int i = 0; i < 100 && (expq.size() != 0 || tb_out != 0 || inst_valid); i++) step();
    check("drain_expected_empty", 64'(expq.size()), 64'd0);
    check("drain_inst_valid", 64'(inst_valid), 64'd0);
    check("drain_outstanding", 64'(tb_out), 64'd0);

`ifdef FETCH_PERF_EN
    check("perf_fetched", 64'(perf_fetched), 64'(n_deliv));
    check("perf_redirects", 64'(perf_redirects), 64'(n_redir));
`else
    check("perf_fetched_off", 64'(perf_fetched), 64'd0);
    check("perf_redirects_off", 64'(perf_redirects), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
